// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the RV32I multi-cycle control unit:
// opcode values, ALU operand/op encodings, FSM state encoding and the
// bundle of datapath select lines driven by the sequencer.
package rv_ctrl_pkg;

  // Major opcodes of the supported RV32I subset (IR[6:0]).
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  // alu_op encoding understood by alu_control.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RFN = 2'b10;
  localparam logic [1:0] ALU_IFN = 2'b11;

  // alu_src_b encoding.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // State encoding is visible on the debug port, so the values are fixed.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  // Datapath select lines decoded from the current state.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  // True for opcodes this sequencer knows how to execute.
  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait timer: counts stalled cycles while a request is pending and
// flags the cycle in which the stall count would reach LIMIT.
module mc_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear wins over enable, otherwise hold.
  always_comb begin
    // NOTE: default assignment first so every path assigns cnt_d (no latch).
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This stalled cycle is the LIMIT-th one: the request has timed out.
  assign expired_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I subset datapath. Owns the shared
// memory port, drives every datapath select from the state register and
// the latched opcode, counts retired instructions and traps on illegal
// opcodes or memory timeouts.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q;
  logic [6:0]       op_q;
  logic             illegal_q;
  logic             bus_err_q;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl;

  logic waiting, tmr_clr, tmr_en, tmr_expired;

  // The timer runs only while a memory request is stalled; any accepted
  // request or any other state clears it.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
  assign tmr_en  = waiting & ~mem_ready;
  assign tmr_clr = ~waiting | mem_ready;

  mc_wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Sequencer: state transitions, opcode latch, sticky traps, retire count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
          end else if (tmr_expired) begin
            state_q   <= S_TRAP;
            bus_err_q <= 1'b1;
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          if (op_supported(opcode)) begin
            state_q <= S_EXEC;
          end else begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_R, OP_I:        state_q <= S_WB;
            OP_LOAD, OP_STORE: state_q <= S_MEM;
            default: begin
              // Branches finish here.
              state_q   <= S_FETCH;
              retired_q <= retired_q + 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op_q == OP_STORE) begin
              state_q   <= S_FETCH;
              retired_q <= retired_q + 1'b1;
            end else begin
              state_q <= S_WB;
            end
          end else if (tmr_expired) begin
            state_q   <= S_TRAP;
            bus_err_q <= 1'b1;
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          retired_q <= retired_q + 1'b1;
        end
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath selects decoded from state_q and op_q; only the FETCH strobes
  // (gated by mem_ready) and the branch PC write look at inputs.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        case (op_q)
          OP_R: begin
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALU_RFN;
          end
          OP_I: begin
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_IFN;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          OP_BR: begin
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_write  = branch_taken;
            ctrl.pc_src    = branch_taken;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.mem_we  = (op_q == OP_STORE);
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = (op_q == OP_LOAD);
      end
      default: ;
    endcase
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign iord       = ctrl.iord;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign state      = state_q;
  assign illegal    = illegal_q;
  assign bus_err    = bus_err_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. A reference model expands each instruction
// (opcode, branch outcome, fetch/memory wait counts) into the per-cycle
// response the control unit must give, drives the matching inputs and
// queues the expected response; a monitor pops and compares every cycle.
module tb_multicycle_control;

  localparam int TO = 12;
  localparam int CW = 4;

  localparam logic [6:0] K_R   = 7'b0110011;
  localparam logic [6:0] K_I   = 7'b0010011;
  localparam logic [6:0] K_LD  = 7'b0000011;
  localparam logic [6:0] K_ST  = 7'b0100011;
  localparam logic [6:0] K_BR  = 7'b1100011;
  localparam logic [6:0] K_JAL = 7'b1101111;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_TRAP = 3'd6;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          branch_taken, mem_ready;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic          alu_src_a, reg_write, mem_to_reg, illegal, bus_err;
  logic [1:0]    alu_src_b, alu_op;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_control #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state),
    .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src, a;
    logic [1:0]    b, aop;
    logic          reg_write, mem_to_reg, illegal, bus_err;
    logic [CW-1:0] retired;
  } obs_t;

  typedef struct {
    obs_t  o;
    bit    achk;   // ALU selects are defined in this state
    string tag;
  } exp_t;

  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state.
  int    m_ret;
  bit    m_ill, m_bus;
  string phase = "init";

  task automatic check(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h (state %0d ret %0d) expected %h (state %0d ret %0d)",
               name, $time, got, got.st, got.retired, want, want.st, want.retired);
    end
  endtask

  // Monitor: compares the DUT against the queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      obs_t act, want;
      e = exp_q.pop_front();
      act = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
             alu_src_b, alu_op, reg_write, mem_to_reg, illegal, bus_err, retired};
      want = e.o;
      if (!e.achk) begin
        act.a = 1'b0; act.b = 2'b00; act.aop = 2'b00;
        want.a = 1'b0; want.b = 2'b00; want.aop = 2'b00;
      end
      check(e.tag, act, want);
    end
  end

  function automatic logic [6:0] rnd7();
    return 7'($urandom);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t o = '0;
    o.st      = st;
    o.retired = CW'(m_ret);
    o.illegal = m_ill;
    o.bus_err = m_bus;
    return o;
  endfunction

  // One clock cycle: apply inputs after the edge, queue the expected response.
  task automatic emit(input obs_t o, input bit chk, input bit achk, input logic rdy,
                      input logic [6:0] op, input logic tk, input logic rv);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rv; mem_ready = rdy; opcode = op; branch_taken = tk;
    if (chk) begin
      e.o = o; e.achk = achk; e.tag = phase;
      exp_q.push_back(e);
    end
  endtask

  task automatic trap_tail(input int n);
    for (int i = 0; i < n; i++) emit(base(ST_TRAP), 1, 1, rnd1(), rnd7(), rnd1(), 1);
  endtask

  task automatic do_reset();
    emit('0, 0, 0, 1'b0, rnd7(), 1'b0, 1'b0);   // state still old this cycle
    m_ret = 0; m_ill = 0; m_bus = 0;
    emit(base(ST_IDLE), 1, 1, 1'b0, rnd7(), 1'b0, 1'b0);
    emit(base(ST_IDLE), 1, 1, rnd1(), rnd7(), rnd1(), 1'b1);
  endtask

  // Fetch stalled wf cycles; a stall of TO cycles is a bus error.
  task automatic do_fetch(input int wf, output bit ok);
    obs_t o;
    ok = 1;
    for (int i = 0; i <= wf; i++) begin
      if (i == TO) begin
        m_bus = 1; ok = 0; trap_tail(4); return;
      end
      o = base(ST_FETCH); o.mem_req = 1; o.b = 2'b01;
      if (i == wf) begin o.ir_write = 1; o.pc_write = 1; end
      emit(o, 1, 1, (i == wf), rnd7(), rnd1(), 1'b1);
    end
  endtask

  // Data access stalled wm cycles; abort >= 0 stops after that many cycles.
  task automatic do_mem(input int wm, input bit store, input int abort, output bit ok);
    obs_t o;
    ok = 1;
    for (int i = 0; i <= wm; i++) begin
      if (abort >= 0 && i == abort) begin ok = 0; return; end
      if (i == TO) begin
        m_bus = 1; ok = 0; trap_tail(4); return;
      end
      o = base(ST_MEM); o.mem_req = 1; o.iord = 1; o.mem_we = store;
      emit(o, 1, 0, (i == wm), rnd7(), rnd1(), 1'b1);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic tk, input int wf,
                           input int wm, input int abort);
    bit   ok;
    obs_t o;
    do_fetch(wf, ok);
    if (!ok) return;
    o = base(ST_DEC); o.b = 2'b10;
    emit(o, 1, 1, rnd1(), op, rnd1(), 1'b1);
    if (!(op inside {K_R, K_I, K_LD, K_ST, K_BR})) begin
      m_ill = 1; trap_tail(4); return;
    end
    o = base(ST_EXEC); o.a = 1;
    case (op)
      K_R:     begin o.b = 2'b00; o.aop = 2'b10; end
      K_I:     begin o.b = 2'b10; o.aop = 2'b11; end
      K_BR:    begin o.b = 2'b00; o.aop = 2'b01; o.pc_write = tk; o.pc_src = tk; end
      default: begin o.b = 2'b10; o.aop = 2'b00; end
    endcase
    emit(o, 1, 1, rnd1(), rnd7(), tk, 1'b1);
    if (op == K_BR) begin m_ret++; return; end
    if (op == K_LD || op == K_ST) begin
      do_mem(wm, (op == K_ST), abort, ok);
      if (!ok) return;
      if (op == K_ST) begin m_ret++; return; end
    end
    o = base(ST_WB); o.reg_write = 1; o.mem_to_reg = (op == K_LD);
    emit(o, 1, 0, rnd1(), rnd7(), rnd1(), 1'b1);
    m_ret++;
  endtask

  initial begin
    logic [6:0] ops [5];
    ops[0] = K_R; ops[1] = K_I; ops[2] = K_LD; ops[3] = K_ST; ops[4] = K_BR;
    rst = 1'b0; mem_ready = 1'b0; opcode = '0; branch_taken = 1'b0;

    phase = "reset";          do_reset();
    phase = "prog_addi";      run_instr(K_I, 0, 0, 0, -1);
    phase = "prog_add";       run_instr(K_R, 0, 0, 0, -1);
    phase = "prog_sw";        run_instr(K_ST, 0, 0, 0, -1);
    phase = "prog_lw";        run_instr(K_LD, 0, 0, 0, -1);
    phase = "beq_taken";      run_instr(K_BR, 1, 0, 0, -1);
    phase = "beq_not_taken";  run_instr(K_BR, 0, 0, 0, -1);
    phase = "fetch_stall10";  run_instr(K_R, 0, 10, 0, -1);
    phase = "ready_at_limit"; run_instr(K_LD, 0, TO - 1, TO - 1, -1);
    phase = "ready_at_limit"; run_instr(K_ST, 0, 0, TO - 1, -1);

    phase = "random";
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 4)], rnd1(), $urandom_range(0, 3),
                $urandom_range(0, 3), -1);

    phase = "reset_mid_mem";  run_instr(K_LD, 0, 0, 5, 3);
    do_reset();
    phase = "after_reset";    run_instr(K_R, 0, 1, 0, -1);

    phase = "fetch_timeout";  run_instr(K_R, 0, TO, 0, -1);
    phase = "reset";          do_reset();
    phase = "mem_timeout";    run_instr(K_ST, 0, 0, TO + 3, -1);
    phase = "reset";          do_reset();
    phase = "illegal_prep";   run_instr(K_I, 0, 0, 0, -1);
    phase = "illegal";        run_instr(K_JAL, 0, 0, 0, -1);
    phase = "reset";          do_reset();
    phase = "after_illegal";  run_instr(K_BR, 1, 0, 0, -1);

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
